pll_phase_ctrl: RTL and testbench
=================================

Name: pll_phase_ctrl

Overview:
Run-time supervisor for an ECP5 EHXPLLL clock generator. It sequences PLL reset, qualifies the lock signal, and retries lock automatically. It drives the PLL dynamic phase-shift pins (PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG) from a valid/ready step-request interface. It sits beside the video/system PLL wrapper, clocked from the PLL reference clock, and replaces tied-off phase pins with a CPU- or calibration-driven controller.

Parameters:
NUM_OUTPUTS, 4, number of PLL outputs eligible for phase shifting (1..4).
STEP_W, 8, width of the step-count field.
RST_CYCLES, 16, cycles that pll_rst is held high per reset attempt (>=1).
LOCK_FILTER, 1024, consecutive synchronised-lock-high cycles required before declaring lock.
LOCK_TIMEOUT, 65536, cycles in WAIT_LOCK before a retry.
STEP_PULSE, 4, cycles PHASESTEP is high, and also the low gap between pulses (>=2).
SETTLE_CYCLES, 64, quiet cycles after the last step before re-accepting requests.

Ports:
clk  in  1  reference clock (PLL CLKI domain).
reset  in  1  asynchronous, active-high reset.
pll_lock  in  1  raw PLL LOCK; asynchronous, double-flop synchronised internally.
pll_rst  out  1  to PLL RST.
pll_phasesel  out  2  to PHASESEL1:0.
pll_phasedir  out  1  to PHASEDIR.
pll_phasestep  out  1  to PHASESTEP.
pll_phaseloadreg  out  1  to PHASELOADREG.
req_valid  in  1  step request valid.
req_ready  out  1  request accepted when valid&&ready.
req_chan  in  2  output select (0=CLKOP..3=CLKOS3).
req_dir  in  1  0=delay, 1=advance (passed to PHASEDIR).
req_steps  in  STEP_W  number of phase steps.
req_err  out  1  one-cycle pulse: request rejected (chan>=NUM_OUTPUTS).
locked  out  1  qualified lock.
relock_count  out  8  saturating count of lock losses plus timeouts.

Behaviour:
- Reset values:
  - pll_rst=1; locked=0; req_ready=0; req_err=0; relock_count=0.
  - pll_phasestep=0; pll_phaseloadreg=0; pll_phasedir=0; pll_phasesel=0.
  - State=RESET_PLL with counter cleared.
- All outputs are registered. No combinational path from inputs to outputs.
- Lock qualification: lock_s is pll_lock after 2 flops. The filter counter increments while lock_s=1 and clears on lock_s=0. The lock condition is filter count == LOCK_FILTER-1 with lock_s=1.
- FSM states:
  - RESET_PLL: pll_rst=1 for RST_CYCLES, then WAIT_LOCK.
  - WAIT_LOCK: pll_rst=0. If the lock condition holds, go to IDLE and set locked=1 on the next edge. If the timeout counter reaches LOCK_TIMEOUT-1 first, go to RESET_PLL and increment relock_count.
  - IDLE: req_ready=1 (registered, valid the cycle after entry). On accept, latch chan/dir/steps and drop req_ready on the same edge.
    - chan>=NUM_OUTPUTS: pulse req_err one cycle, stay IDLE with req_ready re-asserted next cycle.
    - steps=0: go straight to SETTLE.
    - Otherwise: load pll_phasesel and pll_phasedir, then enter SETUP.
  - SETUP: 1 cycle so sel/dir are stable before the first step edge, then STEP_HI.
  - STEP_HI: pll_phasestep=1 for STEP_PULSE cycles, then STEP_LO.
  - STEP_LO: pll_phasestep=0 for STEP_PULSE cycles, then decrement remaining steps. If remaining is nonzero go to STEP_HI, else SETTLE.
  - SETTLE: SETTLE_CYCLES cycles, then IDLE.
- A request of N steps produces exactly N PHASESTEP rising edges. Duration from accept to req_ready=1 again is 1 + 1 + 2·STEP_PULSE·N + SETTLE_CYCLES + 1 cycles.
- pll_phaseloadreg is held 0. It is reserved for a future mode and is not pulsed.
- Lock loss (lock_s=0) in IDLE, SETUP, STEP_*, or SETTLE:
  - locked drops next edge.
  - Any in-flight request is abandoned; remaining steps are discarded and pll_phasestep is forced to 0.
  - req_ready drops.
  - relock_count increments.
  - Next state is RESET_PLL.
- relock_count saturates at 255 and never wraps.
- req_valid is ignored while req_ready=0. Requesters must hold req_valid and data stable until accepted.
- Asynchronous reset mid-step: all outputs return to reset values immediately, and pll_rst is reasserted.

Decomposition:
- Shared package holds:
  - FSM state enum: RESET_PLL, WAIT_LOCK, IDLE, SETUP, STEP_HI, STEP_LO, SETTLE.
  - Channel-select constants CH_CLKOP..CH_CLKOS3.
- One sub-module: pll_lock_filter (2-flop synchroniser plus LOCK_FILTER counter, output lock_ok). Everything else lives in one FSM with a shared down-counter.

Test Plan:
1. Reset released, model PLL asserts LOCK 100 cycles after pll_rst falls (LOCK_FILTER=8, RST_CYCLES=4) -> pll_rst high exactly 4 cycles; locked rises 2+8 cycles after LOCK; req_ready=1 one cycle later; relock_count=0.
2. LOCK never asserts (LOCK_TIMEOUT=32) -> pll_rst re-pulses every 4+32 cycles; relock_count reads 1, 2, 3 across three retries; locked stays 0.
3. Locked, request chan=2 dir=1 steps=3 (STEP_PULSE=4, SETTLE=8) -> phasesel=2 and phasedir=1 stable ≥1 cycle before first edge; exactly 3 PHASESTEP pulses, each 4 high/4 low; req_ready returns after 1+1+24+8+1=35 cycles.
4. NUM_OUTPUTS=2, request chan=3 -> one-cycle req_err, zero PHASESTEP edges, req_ready=1 again two cycles after accept; steps=0 on chan=0 -> no pulses, SETTLE only.
5. Drop LOCK during second step pulse of a 5-step request -> pll_phasestep=0 and locked=0 within 3 cycles of the drop; no further pulses; FSM in RESET_PLL; relock_count incremented; relocks normally.
6. Assert reset mid-STEP_HI -> pll_phasestep=0 and pll_rst=1 without waiting for a clock edge; full lock sequence repeats after release.

Source files
------------

// File: rtl/pll_phase_ctrl_pkg.sv
// Shared types and helpers for the PLL supervisor / phase-step controller.
package pll_phase_ctrl_pkg;

    // Supervisor FSM states.
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        IDLE      = 3'd2,
        SETUP     = 3'd3,
        STEP_HI   = 3'd4,
        STEP_LO   = 3'd5,
        SETTLE    = 3'd6
    } state_t;

    // PHASESEL encodings of the EHXPLLL outputs.
    localparam logic [1:0] CH_CLKOP  = 2'd0;
    localparam logic [1:0] CH_CLKOS  = 2'd1;
    localparam logic [1:0] CH_CLKOS2 = 2'd2;
    localparam logic [1:0] CH_CLKOS3 = 2'd3;

    // Largest of four cycle limits; sizes the shared cycle counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // 8-bit increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pll_phase_ctrl_lock_filter.sv
// Lock qualifier: double-flop synchroniser on the raw PLL LOCK pin followed by
// a run-length counter; lock_ok is high once lock has been seen continuously.
module pll_lock_filter #(
    parameter int LOCK_FILTER = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_lock,
    output logic lock_ok
);
    localparam int CW = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_FILTER - 1);

    logic          sync1_q, sync1_d;
    logic          lock_s_q, lock_s_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state: shift the synchroniser, count consecutive high samples and
    // hold at the last value so lock_ok stays up while lock persists.
    always_comb begin
        sync1_d  = pll_lock;
        lock_s_d = sync1_q;
        cnt_d    = cnt_q;
        if (!lock_s_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            lock_s_q <= lock_s_d;
            cnt_q    <= cnt_d;
        end
    end

    assign lock_ok = lock_s_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/pll_phase_ctrl.sv
// ECP5 EHXPLLL supervisor: sequences PLL reset, retries lock on timeout or
// loss, and turns valid/ready step requests into PHASESTEP pulse trains.
module pll_phase_ctrl
    import pll_phase_ctrl_pkg::*;
#(
    parameter int NUM_OUTPUTS   = 4,
    parameter int STEP_W        = 8,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_FILTER   = 1024,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STEP_PULSE    = 4,
    parameter int SETTLE_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pll_lock,
    output logic              pll_rst,
    output logic [1:0]        pll_phasesel,
    output logic              pll_phasedir,
    output logic              pll_phasestep,
    output logic              pll_phaseloadreg,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_chan,
    input  logic              req_dir,
    input  logic [STEP_W-1:0] req_steps,
    output logic              req_err,
    output logic              locked,
    output logic [7:0]        relock_count
);
    localparam int CNT_TOP = max4(RST_CYCLES, LOCK_TIMEOUT, STEP_PULSE, SETTLE_CYCLES);
    localparam int CW      = (CNT_TOP > 1) ? $clog2(CNT_TOP) : 1;
    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] PULSE_LAST   = CW'(STEP_PULSE - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [2:0]    NUM_OUT      = 3'(NUM_OUTPUTS);

    logic lock_ok;

    pll_lock_filter #(
        .LOCK_FILTER(LOCK_FILTER)
    ) u_lock_filter (
        .clk     (clk),
        .rst     (reset),
        .pll_lock(pll_lock),
        .lock_ok (lock_ok)
    );

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;        // shared per-state cycle counter
    logic [1:0]        chan_q, chan_d;      // latched request
    logic              dir_q, dir_d;
    logic [STEP_W-1:0] steps_q, steps_d;    // steps still to issue
    logic              pend_q, pend_d;      // request latched, not yet decoded
    logic              pll_rst_q, pll_rst_d;
    logic [1:0]        sel_q, sel_d;
    logic              pdir_q, pdir_d;
    logic              step_q, step_d;
    logic              locked_q, locked_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic [7:0]        relock_q, relock_d;

    // Next-state and registered-output logic for the supervisor FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        chan_d    = chan_q;
        dir_d     = dir_q;
        steps_d   = steps_q;
        pend_d    = pend_q;
        pll_rst_d = pll_rst_q;
        sel_d     = sel_q;
        pdir_d    = pdir_q;
        step_d    = step_q;
        locked_d  = locked_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        relock_d  = relock_q;

        case (state_q)
            RESET_PLL: begin
                pll_rst_d = 1'b1;
                if (cnt_q == RST_LAST) begin
                    state_d   = WAIT_LOCK;
                    cnt_d     = '0;
                    pll_rst_d = 1'b0;
                end
            end
            WAIT_LOCK: begin
                pll_rst_d = 1'b0;
                if (lock_ok) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    locked_d = 1'b1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = RESET_PLL;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                    relock_d  = sat_inc8(relock_q);
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (pend_q) begin
                    // Decode the request latched on the previous edge.
                    pend_d = 1'b0;
                    if ({1'b0, chan_q} >= NUM_OUT) begin
                        err_d = 1'b1;
                    end else if (steps_q == '0) begin
                        state_d = SETTLE;
                    end else begin
                        sel_d   = chan_q;
                        pdir_d  = dir_q;
                        state_d = SETUP;
                    end
                end else if (req_valid && ready_q) begin
                    chan_d  = req_chan;
                    dir_d   = req_dir;
                    steps_d = req_steps;
                    pend_d  = 1'b1;
                end else begin
                    ready_d = 1'b1;
                end
            end
            SETUP: begin
                // sel/dir have been stable for a full cycle; start the first pulse.
                state_d = STEP_HI;
                cnt_d   = '0;
                step_d  = 1'b1;
            end
            STEP_HI: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = STEP_LO;
                    cnt_d   = '0;
                    step_d  = 1'b0;
                end
            end
            STEP_LO: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    steps_d = steps_q - 1'b1;
                    if (steps_q != STEP_W'(1)) begin
                        state_d = STEP_HI;
                        step_d  = 1'b1;
                    end else begin
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d   = RESET_PLL;
                cnt_d     = '0;
                pll_rst_d = 1'b1;
            end
        endcase

        // Losing lock once qualified abandons any work and restarts the PLL.
        if (locked_q && !lock_ok) begin
            state_d   = RESET_PLL;
            cnt_d     = '0;
            pll_rst_d = 1'b1;
            locked_d  = 1'b0;
            step_d    = 1'b0;
            steps_d   = '0;
            pend_d    = 1'b0;
            ready_d   = 1'b0;
            err_d     = 1'b0;
            relock_d  = sat_inc8(relock_q);
        end
    end

    // All FSM state and outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            chan_q    <= CH_CLKOP;
            dir_q     <= 1'b0;
            steps_q   <= '0;
            pend_q    <= 1'b0;
            pll_rst_q <= 1'b1;
            sel_q     <= CH_CLKOP;
            pdir_q    <= 1'b0;
            step_q    <= 1'b0;
            locked_q  <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            relock_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            chan_q    <= chan_d;
            dir_q     <= dir_d;
            steps_q   <= steps_d;
            pend_q    <= pend_d;
            pll_rst_q <= pll_rst_d;
            sel_q     <= sel_d;
            pdir_q    <= pdir_d;
            step_q    <= step_d;
            locked_q  <= locked_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            relock_q  <= relock_d;
        end
    end

    assign pll_rst          = pll_rst_q;
    assign pll_phasesel     = sel_q;
    assign pll_phasedir     = pdir_q;
    assign pll_phasestep    = step_q;
    assign pll_phaseloadreg = 1'b0;   // reserved; never pulsed
    assign req_ready        = ready_q;
    assign req_err          = err_q;
    assign locked           = locked_q;
    assign relock_count     = relock_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl: a behavioural PLL lock model, a pulse
// monitor, a table of step requests and hand-written lock/reset sequences.
module tb_pll_phase_ctrl;
    localparam int NUM_OUTPUTS   = 3;
    localparam int STEP_W        = 8;
    localparam int RST_CYCLES    = 4;
    localparam int LOCK_FILTER   = 8;
    localparam int LOCK_TIMEOUT  = 128;
    localparam int STEP_PULSE    = 4;
    localparam int SETTLE_CYCLES = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              pll_lock = 1'b0;
    logic              pll_rst;
    logic [1:0]        pll_phasesel;
    logic              pll_phasedir;
    logic              pll_phasestep;
    logic              pll_phaseloadreg;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_chan = 2'd0;
    logic              req_dir = 1'b0;
    logic [STEP_W-1:0] req_steps = '0;
    logic              req_err;
    logic              locked;
    logic [7:0]        relock_count;

    always #5 clk = ~clk;

    pll_phase_ctrl #(
        .NUM_OUTPUTS  (NUM_OUTPUTS),
        .STEP_W       (STEP_W),
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_FILTER  (LOCK_FILTER),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STEP_PULSE   (STEP_PULSE),
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pll_lock        (pll_lock),
        .pll_rst         (pll_rst),
        .pll_phasesel    (pll_phasesel),
        .pll_phasedir    (pll_phasedir),
        .pll_phasestep   (pll_phasestep),
        .pll_phaseloadreg(pll_phaseloadreg),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_chan        (req_chan),
        .req_dir         (req_dir),
        .req_steps       (req_steps),
        .req_err         (req_err),
        .locked          (locked),
        .relock_count    (relock_count)
    );

    // PLL model: LOCK rises lock_delay cycles after RST falls, if enabled.
    int lock_delay = 100;
    bit lock_en    = 1'b1;
    int since      = 0;
    always @(negedge clk) begin
        if (pll_rst || !lock_en) begin
            since    = 0;
            pll_lock = 1'b0;
        end else if (since >= lock_delay) begin
            pll_lock = 1'b1;
        end else begin
            since++;
        end
    end

    // Monitor: PHASESTEP rising edges, pulse/gap widths, sel/dir setup, err cycles.
    int   rises = 0, err_cycles = 0, width_bad = 0, setup_bad = 0;
    int   hi_run = 0, lo_run = 0;
    logic prev_step = 1'b0, prev_dir = 1'b0;
    logic [1:0] prev_sel = 2'd0;
    always @(negedge clk) begin
        if (pll_phasestep && !prev_step) begin
            rises++;
            if (pll_phasesel != prev_sel || pll_phasedir != prev_dir) setup_bad++;
            if (lo_run != STEP_PULSE && lo_run < STEP_PULSE + SETTLE_CYCLES) width_bad++;
            hi_run = 1;
        end else if (pll_phasestep) begin
            hi_run++;
        end else if (prev_step) begin
            if (hi_run != STEP_PULSE) width_bad++;
            lo_run = 1;
        end else begin
            lo_run++;
        end
        if (req_err) err_cycles++;
        prev_step = pll_phasestep;
        prev_sel  = pll_phasesel;
        prev_dir  = pll_phasedir;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!req_ready && n < budget) begin tick(); n++; end
    endtask

    task automatic wait_locked(input int budget);
        int n = 0;
        while (!locked && n < budget) begin tick(); n++; end
    endtask

    // Issue one request and return cycles from accept edge to req_ready high.
    task automatic send(input logic [1:0] chan, input logic dir,
                        input logic [STEP_W-1:0] steps, output int lat);
        wait_ready(500);
        req_chan  = chan;
        req_dir   = dir;
        req_steps = steps;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!req_ready && lat < 1000) begin tick(); lat++; end
    endtask

    typedef struct {
        logic [1:0]        chan;
        logic              dir;
        logic [STEP_W-1:0] steps;
        int                exp_err;
        int                exp_rises;
        int                exp_lat;
        int                exp_sel;
        int                exp_dir;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n, lat, r0, e0, w0, s0, rel0;

        // chan, dir, steps | err, rises, accept->ready, sel/dir afterwards
        vecs[0] = '{2'd2, 1'b1, 8'd3, 0, 3, 35, 2, 1};  // 1+1+24+8+1
        vecs[1] = '{2'd3, 1'b0, 8'd5, 1, 0, 2,  2, 1};  // rejected, sel/dir untouched
        vecs[2] = '{2'd0, 1'b0, 8'd0, 0, 0, 10, 2, 1};  // straight to SETTLE: 1+8+1
        vecs[3] = '{2'd1, 1'b0, 8'd1, 0, 1, 19, 1, 0};  // 1+1+8+8+1
        vecs[4] = '{2'd0, 1'b1, 8'd2, 0, 2, 27, 0, 1};  // 1+1+16+8+1

        // ---- reset values ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_pll_rst", pll_rst, 1);
        check("rst_locked", locked, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_req_err", req_err, 0);
        check("rst_relock", relock_count, 0);
        check("rst_phasestep", pll_phasestep, 0);
        check("rst_loadreg", pll_phaseloadreg, 0);
        check("rst_phasedir", pll_phasedir, 0);
        check("rst_phasesel", pll_phasesel, 0);

        // ---- first lock ----
        reset = 1'b0;
        n = 0;
        while (pll_rst && n < 100) begin tick(); n++; end
        check("t1_rst_width", n, RST_CYCLES);
        n = 0;
        while (!pll_lock && n < 300) begin tick(); n++; end
        // the first synchroniser edge after LOCK rose is already behind us
        n = 1;
        while (!locked && n < 100) begin tick(); n++; end
        check("t1_lock_latency", n, 2 + LOCK_FILTER);
        check("t1_ready_at_lock", req_ready, 0);
        tick();
        check("t1_ready_after_lock", req_ready, 1);
        check("t1_relock", relock_count, 0);

        // ---- table of step requests ----
        for (int i = 0; i < 5; i++) begin
            r0 = rises; e0 = err_cycles; w0 = width_bad; s0 = setup_bad;
            send(vecs[i].chan, vecs[i].dir, vecs[i].steps, lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_rises", i), rises - r0, vecs[i].exp_rises);
            check($sformatf("v%0d_err", i), err_cycles - e0, vecs[i].exp_err);
            check($sformatf("v%0d_sel", i), pll_phasesel, vecs[i].exp_sel);
            check($sformatf("v%0d_dir", i), pll_phasedir, vecs[i].exp_dir);
            check($sformatf("v%0d_widths", i), width_bad - w0, 0);
            check($sformatf("v%0d_setup", i), setup_bad - s0, 0);
            $display("vec %0d chan=%0d dir=%0d steps=%0d lat=%0d rises=%0d err=%0d",
                     i, vecs[i].chan, vecs[i].dir, vecs[i].steps, lat,
                     rises - r0, err_cycles - e0);
        end

        // ---- lock lost during the second pulse of a 5-step request ----
        r0 = rises;
        rel0 = relock_count;
        wait_ready(500);
        req_chan = 2'd1; req_dir = 1'b0; req_steps = 8'd5; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (rises - r0 < 2 && n < 200) begin tick(); n++; end
        check("t5_two_pulses", rises - r0, 2);
        lock_en = 1'b0;
        n = 0;
        while (pll_lock && n < 10) begin tick(); n++; end
        tick();
        check("t5_locked_before_react", locked, 1);
        tick();
        check("t5_locked_dropped", locked, 0);
        check("t5_step_forced_low", pll_phasestep, 0);
        check("t5_pll_rst", pll_rst, 1);
        check("t5_ready_dropped", req_ready, 0);
        check("t5_relock_inc", relock_count, rel0 + 1);
        r0 = rises;
        lock_en = 1'b1;
        wait_locked(400);
        check("t5_relocked", locked, 1);
        check("t5_no_more_pulses", rises - r0, 0);
        check("t5_relock_kept", relock_count, rel0 + 1);
        wait_ready(50);
        check("t5_ready_again", req_ready, 1);

        // ---- asynchronous reset in the middle of STEP_HI ----
        req_chan = 2'd0; req_dir = 1'b1; req_steps = 8'd2; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!pll_phasestep && n < 20) begin tick(); n++; end
        check("t6_in_step_hi", pll_phasestep, 1);
        #2 reset = 1'b1;
        #1;
        check("t6_step_cleared", pll_phasestep, 0);
        check("t6_pll_rst", pll_rst, 1);
        check("t6_locked", locked, 0);
        check("t6_ready", req_ready, 0);
        check("t6_phasedir", pll_phasedir, 0);
        tick();
        reset = 1'b0;
        n = 0;
        while (pll_rst && n < 100) begin tick(); n++; end
        check("t6_rst_width", n, RST_CYCLES);
        wait_locked(400);
        check("t6_relocked", locked, 1);
        check("t6_relock_cleared", relock_count, 0);

        // ---- LOCK never comes: periodic retries and saturation ----
        lock_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        while (pll_rst && n < 100) begin tick(); n++; end
        for (int k = 1; k <= 3; k++) begin
            n = 0;
            while (!pll_rst && n < 500) begin tick(); n++; end
            check($sformatf("t2_wait_width_%0d", k), n, LOCK_TIMEOUT);
            check($sformatf("t2_relock_%0d", k), relock_count, k);
            n = 0;
            while (pll_rst && n < 100) begin tick(); n++; end
            check($sformatf("t2_rst_width_%0d", k), n, RST_CYCLES);
            check($sformatf("t2_locked_%0d", k), locked, 0);
        end
        n = 0;
        while (relock_count != 8'd255 && n < 40000) begin tick(); n++; end
        check("t2_relock_reaches_255", relock_count, 255);
        repeat (300) tick();
        check("t2_relock_saturated", relock_count, 255);
        check("t2_never_locked", locked, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
